ccff_chain_loader: RTL and testbench
====================================

# ccff_chain_loader

Sequences configuration of the tile array's configuration-chain (ccff) flip-flops. Accepts bitstream words from the host over a valid/ready port and shifts exactly CHAIN_LEN bits serially into `ccff_head`, one bit per enabled `prog_clk` cycle. It simultaneously captures the previous chain contents emerging on `ccff_tail` into readback words. It sits between the host configuration port and the head of the grid's ccff chain, and replaces free-running shifting with a counted, stallable, abortable sequence.

## Interface
- `WORD_W`, 32: bitstream word width.
- `CHAIN_LEN`, 1024: total ccff bits in the chain, ≥1.
- `CNT_W`, $clog2(CHAIN_LEN+1): bit counter width.
- `prog_clk`  in  1  sole clock; all logic is rising-edge.
- `pReset`  in  1  reset, synchronous and active-high.
- `start`  in  1  one-cycle pulse to begin a load; ignored unless IDLE or DONE.
- `abort`  in  1  terminates the load and returns to IDLE next cycle.
- `word_valid`  in  1  host word available.
- `word_data`  in  WORD_W  bitstream word; bit 0 is shifted first.
- `word_ready`  out  1  loader accepts a word this cycle.
- `ccff_head`  out  1  serial data into the chain (registered).
- `ccff_shift_en`  out  1  chain shifts on the next `prog_clk` edge (registered).
- `ccff_tail`  in  1  serial data out of the chain.
- `rb_valid`  out  1  one-cycle pulse; `rb_data` holds a complete readback word.
- `rb_data`  out  WORD_W  captured tail bits; bit 0 is the first bit out.
- `busy`  out  1  high in LOAD or SHIFT.
- `done`  out  1  high in DONE until the next `start`, `abort` or reset.
- `bit_count`  out  CNT_W  bits shifted so far in the current load.

## Operation
- States:
  - IDLE: waits for a `start` pulse.
  - LOAD: waits for a word.
  - SHIFT: drains the shift register into the chain.
  - DONE: load complete.
- Transitions:
  - IDLE/DONE + `start` → LOAD. Clears `bit_count` and the readback accumulator; clears `done`.
  - LOAD: `word_ready`=1. On `word_valid && word_ready`, latch the word into the shift register, set the word-bit index to 0, then → SHIFT.
  - SHIFT: each cycle, drive the register's bit 0 to `ccff_head`, assert `ccff_shift_en`, and right-shift the register. Increment `bit_count` and the word-bit index.
  - SHIFT, after bit WORD_W-1 is shifted and `bit_count` < CHAIN_LEN → LOAD.
  - SHIFT, once `bit_count` reaches CHAIN_LEN (including mid-word) → DONE. Unused upper bits of the final word are discarded.
- Readback:
  - On every cycle where `ccff_shift_en` is high, sample `ccff_tail` into the accumulator at the current word-bit index.
  - `rb_valid` pulses when the accumulator holds WORD_W bits, or on the final bit of the load. A final partial word is zero-filled in its unused upper bits.
  - There is no readback backpressure; the host must accept `rb_valid` unconditionally.
- Host stall: in LOAD, `ccff_shift_en`=0 and `ccff_head` holds its last value. The chain is frozen and no bits are lost.
- `abort` or `pReset` in any state → IDLE. `ccff_shift_en` deasserts on the same edge and any partial word is dropped. Chain contents are left undefined and `done` stays 0.
- `start` while busy is ignored. `start` and `abort` in the same cycle: `abort` wins.

## Timing
- Reset values:
  - state=IDLE
  - `word_ready`=0, `ccff_head`=0, `ccff_shift_en`=0
  - `rb_valid`=0, `rb_data`=0
  - `busy`=0, `done`=0, `bit_count`=0
- `start` accepted at edge N → `word_ready`=1 from cycle N+1.
- Word handshake at edge M:
  - First `ccff_shift_en`/`ccff_head` bit at cycle M+1.
  - WORD_W consecutive shift cycles follow, then `word_ready` reasserts in the next cycle.
- Minimum per-word cost is WORD_W+1 cycles, so a back-to-back host sees a one-cycle LOAD bubble per word.
- `ccff_tail` is sampled in the same cycle `ccff_shift_en`=1, i.e. the value before that shift.
- `rb_valid` asserts the cycle after the last contributing tail sample.
- `done` rises the cycle after the CHAIN_LEN-th shift cycle.

## Structure
- Shared package `ccff_pkg`:
  - state enum `ccff_ld_state_t` (IDLE, LOAD, SHIFT, DONE)
  - default WORD_W
  - helper function for the number of words per chain, ceil(CHAIN_LEN/WORD_W)
- Single flat module; no sub-module is needed. The readback accumulator stays inline because it shares the word-bit index.

## Test plan
- CHAIN_LEN=64, WORD_W=32, `word_valid` held high with words 0xA5A5_0001 and 0x8000_00FF, chain modeled as a 64-bit shift register preset to 0xDEAD_BEEF_0123_4567:
  - `ccff_shift_en` is high for exactly 64 cycles, with one bubble between words.
  - Model ends at {0x8000_00FF, 0xA5A5_0001}.
  - `rb_data` returns 0x0123_4567, then 0xDEAD_BEEF.
  - `done`=1, `bit_count`=64.
- CHAIN_LEN=40: the second word shifts only 8 bits. The final `rb_data` upper 24 bits are 0 and `done` rises after shift 40.
- Host stall: hold `word_valid`=0 for 10 cycles between words. `ccff_shift_en`=0 and `ccff_head` stays stable throughout, and the final chain contents are identical to the no-stall run.
- `abort` asserted at shift 17 of word 1:
  - Next cycle: state IDLE, `ccff_shift_en`=0, `busy`=0, `done`=0.
  - A subsequent `start` restarts from `bit_count`=0.
- `pReset` pulsed mid-SHIFT: all outputs take their reset values on the next edge.
- `start` and `abort` in the same cycle from DONE: the block goes to IDLE.
- `start` while busy: no effect on `bit_count`.

Source files
------------

// File: rtl/ccff_pkg.sv
// Shared types and helpers for the configuration-chain loader.
package ccff_pkg;

   // Loader sequencing states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } ccff_ld_state_t;

   // Default host bitstream word width.
   localparam int WORD_W_DEF = 32;

   // Number of host words needed to cover a chain: ceil(chain_len / word_w).
   function automatic int words_per_chain(input int chain_len, input int word_w);
      return (chain_len + word_w - 1) / word_w;
   endfunction

endpackage

// File: rtl/ccff_chain_loader.sv
// Counted, stallable, abortable loader for the tile array's ccff chain.
// Shifts CHAIN_LEN bits into ccff_head (LSB of each host word first) and
// gathers the bits emerging on ccff_tail into readback words.
//
// Handshake: a host word transfers on every rising edge where
// word_valid && word_ready. word_ready is high exactly while in LOAD and
// does not depend on word_valid. rb_valid is a one-cycle pulse with no
// backpressure; rb_data stays stable until the next pulse.
module ccff_chain_loader
   import ccff_pkg::*;
#(
   parameter int WORD_W    = WORD_W_DEF,
   parameter int CHAIN_LEN = 1024,
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              start,
   input  logic              abort,
   input  logic              word_valid,
   input  logic [WORD_W-1:0] word_data,
   output logic              word_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   input  logic              ccff_tail,
   output logic              rb_valid,
   output logic [WORD_W-1:0] rb_data,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  bit_count,
   output ccff_ld_state_t    dbg_state
);

   localparam int               IDX_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN);

   ccff_ld_state_t    r_state;
   logic [WORD_W-1:0] r_shreg;
   logic [WORD_W-1:0] r_acc;
   logic [WORD_W-1:0] r_rb_data;
   logic [IDX_W-1:0]  r_bit_idx;
   logic [CNT_W-1:0]  r_bit_count;
   logic              r_head;
   logic              r_shift_en;
   logic              r_rb_valid;

   logic [WORD_W-1:0] w_acc_next;
   logic [CNT_W-1:0]  w_count_next;
   logic              w_last_bit;
   logic              w_word_end;

   // The bit on the wire this cycle is word bit r_bit_idx; the chain's
   // count after this shift decides whether the load ends here.
   assign w_count_next = r_bit_count + 1'b1;
   assign w_last_bit   = (w_count_next == CNT_LAST);
   assign w_word_end   = (r_bit_idx == IDX_LAST);

   // Readback accumulator with the current tail bit merged at the word-bit index.
   always_comb begin
      w_acc_next            = r_acc;
      w_acc_next[r_bit_idx] = ccff_tail;
   end

   // Load sequencer: state, shift register, counters and readback capture.
   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         r_state     <= IDLE;
         r_shreg     <= '0;
         r_acc       <= '0;
         r_rb_data   <= '0;
         r_bit_idx   <= '0;
         r_bit_count <= '0;
         r_head      <= 1'b0;
         r_shift_en  <= 1'b0;
         r_rb_valid  <= 1'b0;
      end else if (abort) begin
         // Partial readback is dropped; ccff_head keeps its last value.
         r_state    <= IDLE;
         r_shift_en <= 1'b0;
         r_rb_valid <= 1'b0;
         r_acc      <= '0;
      end else begin
         r_rb_valid <= 1'b0;
         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_state     <= LOAD;
                  r_bit_count <= '0;
                  r_acc       <= '0;
               end
            end
            LOAD: begin
               // Present bit 0 straight away so the first shift is the next cycle.
               if (word_valid) begin
                  r_shreg    <= word_data >> 1;
                  r_head     <= word_data[0];
                  r_shift_en <= 1'b1;
                  r_bit_idx  <= '0;
                  r_state    <= SHIFT;
               end
            end
            SHIFT: begin
               r_bit_count <= w_count_next;
               if (w_last_bit || w_word_end) begin
                  // Unused upper bits of a final partial word stay zero.
                  r_rb_valid <= 1'b1;
                  r_rb_data  <= w_acc_next;
                  r_acc      <= '0;
                  r_shift_en <= 1'b0;
                  r_state    <= w_last_bit ? DONE : LOAD;
               end else begin
                  r_acc     <= w_acc_next;
                  r_head    <= r_shreg[0];
                  r_shreg   <= r_shreg >> 1;
                  r_bit_idx <= r_bit_idx + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign word_ready    = (r_state == LOAD);
   assign busy          = (r_state == LOAD) || (r_state == SHIFT);
   assign done          = (r_state == DONE);
   assign ccff_head     = r_head;
   assign ccff_shift_en = r_shift_en;
   assign rb_valid      = r_rb_valid;
   assign rb_data       = r_rb_data;
   assign bit_count     = r_bit_count;
   assign dbg_state     = r_state;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a modelled ccff chain driven by the DUT,
// a host driver, and a readback scoreboard fed from chain snapshots.
module tb_ccff_chain_loader;
   import ccff_pkg::*;

   localparam int W  = 32;
   localparam int CL = 40;
   localparam int CW = $clog2(CL + 1);
   localparam int NW = words_per_chain(CL, W);

   // ---------------- clock / reset ----------------
   logic prog_clk = 1'b0;
   always #5 prog_clk = ~prog_clk;

   logic           pReset;
   logic           start;
   logic           abort;
   logic           word_valid;
   logic [W-1:0]   word_data;
   logic           word_ready;
   logic           ccff_head;
   logic           ccff_shift_en;
   logic           ccff_tail;
   logic           rb_valid;
   logic [W-1:0]   rb_data;
   logic           busy;
   logic           done;
   logic [CW-1:0]  bit_count;
   ccff_ld_state_t dbg_state;

   ccff_chain_loader #(.WORD_W(W), .CHAIN_LEN(CL)) u_dut (
      .prog_clk      (prog_clk),
      .pReset        (pReset),
      .start         (start),
      .abort         (abort),
      .word_valid    (word_valid),
      .word_data     (word_data),
      .word_ready    (word_ready),
      .ccff_head     (ccff_head),
      .ccff_shift_en (ccff_shift_en),
      .ccff_tail     (ccff_tail),
      .rb_valid      (rb_valid),
      .rb_data       (rb_data),
      .busy          (busy),
      .done          (done),
      .bit_count     (bit_count),
      .dbg_state     (dbg_state)
   );

   // ---------------- chain model (environment) ----------------
   logic [CL-1:0] chain;
   logic          preset_req = 1'b0;
   logic [CL-1:0] preset_val = '0;
   int            shift_cnt  = 0;

   assign ccff_tail = chain[0];

   always @(posedge prog_clk) begin
      if (preset_req) begin
         chain <= preset_val;
      end else if (ccff_shift_en) begin
         chain     <= {ccff_head, chain[CL-1:1]};
         shift_cnt <= shift_cnt + 1;
      end
   end

   // ---------------- reference model / scoreboard ----------------
   logic [W-1:0]  exp_q[$];
   logic [CL-1:0] model_chain;
   int            n_cmp = 0;
   int            n_bad = 0;
   logic          prev_head = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: readback words against the scoreboard; frozen chain while stalled.
   always @(negedge prog_clk) begin
      if (rb_valid === 1'b1) begin
         if (exp_q.size() == 0) chk("rb_unexpected", {32'd0, rb_data}, 64'hFFFF_FFFF_FFFF_FFFF);
         else                   chk("rb_data", rb_data, exp_q.pop_front());
      end
      if (pReset === 1'b0 && word_ready === 1'b1) begin
         chk("stall_shift_en", ccff_shift_en, 0);
         chk("stall_head", ccff_head, prev_head);
      end
      prev_head <= ccff_head;
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge prog_clk);
      #1;
   endtask

   task automatic preset(input logic [CL-1:0] v);
      preset_val  = v;
      preset_req  = 1'b1;
      tick();
      preset_req  = 1'b0;
      model_chain = v;
   endtask

   function automatic logic [CL-1:0] rand_chain();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[CL-1:0];
   endfunction

   function automatic logic [NW*W-1:0] rand_bits();
      logic [NW*W-1:0] r;
      for (int k = 0; k < NW; k++) r[k*W +: W] = $urandom();
      return r;
   endfunction

   // Waits for word_ready, optionally stalls, then hands one word over.
   task automatic send_word(input logic [W-1:0] d, input int gap);
      int t;
      t = 0;
      if (gap > 0) word_valid = 1'b0;
      while (word_ready !== 1'b1 && t < 100) begin
         tick();
         t++;
      end
      chk("word_ready_wait", word_ready, 1);
      repeat (gap) tick();
      word_valid = 1'b1;
      word_data  = d;
      tick();
   endtask

   task automatic check_reset_vals();
      chk("rst_state", dbg_state, IDLE);
      chk("rst_word_ready", word_ready, 0);
      chk("rst_head", ccff_head, 0);
      chk("rst_shift_en", ccff_shift_en, 0);
      chk("rst_rb_valid", rb_valid, 0);
      chk("rst_rb_data", rb_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_bit_count", bit_count, 0);
   endtask

   // One complete load; expected readback is the chain as it stood before.
   task automatic run_load(input logic [NW*W-1:0] bits, input int gap_lo, input int gap_hi,
                           input bit busy_start);
      logic [NW*W-1:0] padded;
      logic [CW-1:0]   bc;
      int              sc0;
      int              t;
      padded         = '0;
      padded[CL-1:0] = model_chain;
      for (int k = 0; k < NW; k++) exp_q.push_back(padded[k*W +: W]);
      model_chain = bits[CL-1:0];
      sc0 = shift_cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_bit_count", bit_count, 0);
      chk("start_word_ready", word_ready, 1);
      chk("start_done", done, 0);
      for (int k = 0; k < NW; k++) begin
         send_word(bits[k*W +: W], (k == 0) ? 0 : int'($urandom_range(gap_hi, gap_lo)));
         if (busy_start && k == 0) begin
            repeat (3) tick();
            bc    = bit_count;
            start = 1'b1;
            tick();
            start = 1'b0;
            chk("busy_start_count", bit_count, bc + 1);
            chk("busy_start_busy", busy, 1);
         end
      end
      word_valid = 1'b0;
      t = 0;
      while (done !== 1'b1 && t < W + 20) begin
         tick();
         t++;
      end
      chk("load_done", done, 1);
      chk("load_bit_count", bit_count, CL);
      chk("load_shift_cycles", shift_cnt - sc0, CL);
      chk("load_chain", chain, model_chain);
      chk("load_state", dbg_state, DONE);
      chk("load_busy", busy, 0);
   endtask

   // ---------------- stimulus ----------------
   logic [NW*W-1:0] dir_bits;

   initial begin
      int t;
      pReset     = 1'b1;
      start      = 1'b0;
      abort      = 1'b0;
      word_valid = 1'b0;
      word_data  = '0;
      dir_bits   = {32'h8000_00FF, 32'hA5A5_0001};
      repeat (3) tick();
      check_reset_vals();
      pReset = 1'b0;
      tick();

      // Directed words, back-to-back host; second word only partly used.
      preset(40'hEF_0123_4567);
      run_load(dir_bits, 0, 0, 1'b0);
      repeat (3) tick();
      chk("done_hold", done, 1);

      // Same load with a 10-cycle host stall between words.
      preset(40'hEF_0123_4567);
      run_load(dir_bits, 10, 10, 1'b0);

      // Random words and random stalls; readback is the previous load.
      for (int i = 0; i < 4; i++) run_load(rand_bits(), 0, 12, i == 1);

      // start and abort together from DONE: abort wins.
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("sa_state", dbg_state, IDLE);
      chk("sa_done", done, 0);
      chk("sa_busy", busy, 0);

      // Abort on shift 17 of the first word.
      start = 1'b1;
      tick();
      start = 1'b0;
      send_word($urandom(), 0);
      t = 0;
      while (bit_count !== CW'(16) && t < 100) begin
         tick();
         t++;
      end
      chk("abort_reach", bit_count, 16);
      chk("abort_pre_shift_en", ccff_shift_en, 1);
      abort      = 1'b1;
      word_valid = 1'b0;
      tick();
      abort = 1'b0;
      chk("abort_state", dbg_state, IDLE);
      chk("abort_shift_en", ccff_shift_en, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      preset(rand_chain());
      run_load(rand_bits(), 0, 3, 1'b0);

      // Reset pulsed mid-shift.
      start = 1'b1;
      tick();
      start = 1'b0;
      send_word($urandom(), 0);
      repeat (5) tick();
      chk("prst_pre_shift_en", ccff_shift_en, 1);
      pReset     = 1'b1;
      word_valid = 1'b0;
      tick();
      check_reset_vals();
      pReset = 1'b0;
      tick();
      preset(rand_chain());
      run_load(rand_bits(), 0, 5, 1'b0);

      repeat (5) tick();
      chk("exp_q_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

endmodule
